regfile_immgen: RTL and testbench

Decode-stage datapath block of the single-issue RV32I core: a 32 x 32-bit integer register file (two combinational read ports, one synchronous write port, x0 hardwired to zero) plus a purely combinational immediate generator that extracts and sign-extends the immediate of the current instruction. It sits between instruction fetch and the ALU/branch unit, feeding operand A/B and the immediate operand.

---
 rtl/regfile_immgen_if.sv | 23 ++
 rtl/regfile_immgen.sv | 62 ++++++
 tb/tb_regfile_immgen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/regfile_immgen_if.sv
// Decode-stage bus between the fetch/control side and the register file plus immediate generator.
// The master drives indices, write data and the instruction; the slave returns operands and the immediate.
interface regfile_immgen_if;
  logic        reg_write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] instruction;
  logic [31:0] imm_extended;

  modport master (
    output reg_write_en, write_addr, write_data, read_addr1, read_addr2, instruction,
    input  read_data1, read_data2, imm_extended
  );

  modport slave (
    input  reg_write_en, write_addr, write_data, read_addr1, read_addr2, instruction,
    output read_data1, read_data2, imm_extended
  );
endinterface

// File: rtl/regfile_immgen.sv
// RV32I decode datapath: 32x32 register file (2 async reads, 1 sync write, x0 = 0)
// and a combinational sign-extending immediate generator.
module regfile_immgen (
  input  logic             clk,
  input  logic             rst,
  regfile_immgen_if.slave  bus
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  logic [31:0] regs [32];
  logic [31:0] inst;
  logic [31:0] imm;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  // This array is cleared on reset because the architecture guarantees zeroed registers after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.reg_write_en && (bus.write_addr != 5'd0)) begin
      regs[bus.write_addr] <= bus.write_data;
    end
  end

  // x0 is forced to zero on the read side so it holds even before the first reset.
  assign bus.read_data1 = (bus.read_addr1 == 5'd0) ? 32'h0 : regs[bus.read_addr1];
  assign bus.read_data2 = (bus.read_addr2 == 5'd0) ? 32'h0 : regs[bus.read_addr2];

  assign inst = bus.instruction;

  // NOTE: imm gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    imm = 32'h0;
    case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {inst[31:12], 12'h0};
      OP_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = 32'h0;
    endcase
  end

  assign bus.imm_extended = imm;

endmodule

// File: tb/tb_regfile_immgen.sv
// Self-checking bench for regfile_immgen: table-driven register and immediate vectors
// plus hand-written sequences for x0, read-during-write and reset-over-write behaviour.
module tb_regfile_immgen;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  regfile_immgen_if bus ();

  regfile_immgen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] imm;
  } imm_vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } reg_vec_t;

  imm_vec_t imm_vecs [14];
  reg_vec_t reg_vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.reg_write_en = 1'b1;
    bus.write_addr   = addr;
    bus.write_data   = data;
    @(posedge clk);
    #1;
    bus.reg_write_en = 1'b0;
  endtask

  task automatic read_pair(input logic [4:0] a1, input logic [4:0] a2);
    bus.read_addr1 = a1;
    bus.read_addr2 = a2;
    #1;
  endtask

  initial begin
    imm_vecs[0]  = '{"addi_neg",   32'hFFB00093, 32'hFFFFFFFB};
    imm_vecs[1]  = '{"sw_pos",     32'h00112A23, 32'h00000014};
    imm_vecs[2]  = '{"beq_pos",    32'h00008E63, 32'h0000001C};
    // FE000EE3 encodes beq x0,x0,-4: imm[11]=inst[7]=1, imm[4:1]=1110 -> -4.
    imm_vecs[3]  = '{"beq_neg",    32'hFE000EE3, 32'hFFFFFFFC};
    imm_vecs[4]  = '{"lui",        32'h123450B7, 32'h12345000};
    imm_vecs[5]  = '{"jal_pos",    32'h0080006F, 32'h00000008};
    imm_vecs[6]  = '{"rtype",      32'h00000033, 32'h00000000};
    imm_vecs[7]  = '{"lw_neg",     32'h80002083, 32'hFFFFF800};
    imm_vecs[8]  = '{"jalr",       32'h7FF080E7, 32'h000007FF};
    imm_vecs[9]  = '{"auipc_neg",  32'hFFFFF097, 32'hFFFFF000};
    imm_vecs[10] = '{"jal_neg",    32'hFFDFF06F, 32'hFFFFFFFC};
    imm_vecs[11] = '{"sw_neg",     32'hFE112E23, 32'hFFFFFFFC};
    imm_vecs[12] = '{"system",     32'h30200073, 32'h00000302};
    imm_vecs[13] = '{"bad_opcode", 32'hFFFFFFFF, 32'h00000000};

    reg_vecs[0] = '{5'd1,  32'h00000001};
    reg_vecs[1] = '{5'd2,  32'hFFFFFFFF};
    reg_vecs[2] = '{5'd15, 32'hA5A5A5A5};
    reg_vecs[3] = '{5'd16, 32'h5A5A5A5A};
    reg_vecs[4] = '{5'd30, 32'h80000000};
    reg_vecs[5] = '{5'd31, 32'h7FFFFFFF};
    reg_vecs[6] = '{5'd7,  32'h11111111};
    reg_vecs[7] = '{5'd12, 32'hCAFEF00D};

    rst              = 1'b1;
    bus.reg_write_en = 1'b0;
    bus.write_addr   = '0;
    bus.write_data   = '0;
    bus.read_addr1   = '0;
    bus.read_addr2   = '0;
    bus.instruction  = 32'h00000033;

    repeat (2) @(posedge clk);
    #1;
    read_pair(5'd5, 5'd31);
    check("reset_x5",  bus.read_data1, 32'h0);
    check("reset_x31", bus.read_data2, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic write and x0 read on the second port.
    write_reg(5'd5, 32'hABCDEFFF);
    read_pair(5'd5, 5'd0);
    check("x5_rd1", bus.read_data1, 32'hABCDEFFF);
    check("x0_rd2", bus.read_data2, 32'h0);

    // Writes to x0 are discarded.
    write_reg(5'd0, 32'h12345678);
    read_pair(5'd0, 5'd0);
    check("x0_write_rd1", bus.read_data1, 32'h0);
    check("x0_write_rd2", bus.read_data2, 32'h0);

    // Table write-back, then read on both ports with distinct address pairs.
    foreach (reg_vecs[i]) write_reg(reg_vecs[i].addr, reg_vecs[i].data);
    for (int i = 0; i < 8; i++) begin
      int j;
      j = (i + 3) % 8;
      read_pair(reg_vecs[i].addr, reg_vecs[j].addr);
      check($sformatf("tbl_rd1_x%0d", reg_vecs[i].addr), bus.read_data1, reg_vecs[i].data);
      check($sformatf("tbl_rd2_x%0d", reg_vecs[j].addr), bus.read_data2, reg_vecs[j].data);
    end
    read_pair(5'd5, 5'd5);
    check("x5_kept_rd1", bus.read_data1, 32'hABCDEFFF);
    check("x5_kept_rd2", bus.read_data2, 32'hABCDEFFF);

    // Strobe low must not write.
    @(negedge clk);
    bus.write_addr = 5'd12;
    bus.write_data = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    read_pair(5'd12, 5'd0);
    check("no_en_x12", bus.read_data1, 32'hCAFEF00D);

    // Read-during-write on x7: old value before the edge, new value after.
    @(negedge clk);
    bus.reg_write_en = 1'b1;
    bus.write_addr   = 5'd7;
    bus.write_data   = 32'h22222222;
    read_pair(5'd7, 5'd7);
    check("rdw_old_rd1", bus.read_data1, 32'h11111111);
    check("rdw_old_rd2", bus.read_data2, 32'h11111111);
    @(posedge clk);
    #1;
    check("rdw_new_rd1", bus.read_data1, 32'h22222222);
    check("rdw_new_rd2", bus.read_data2, 32'h22222222);

    // Reset takes priority over a simultaneous write.
    @(negedge clk);
    bus.write_addr = 5'd9;
    bus.write_data = 32'h0000DEAD;
    rst            = 1'b1;
    @(posedge clk);
    #1;
    rst              = 1'b0;
    bus.reg_write_en = 1'b0;
    read_pair(5'd9, 5'd7);
    check("rst_pri_x9", bus.read_data1, 32'h0);
    check("rst_pri_x7", bus.read_data2, 32'h0);
    read_pair(5'd5, 5'd31);
    check("rst_mid_x5",  bus.read_data1, 32'h0);
    check("rst_mid_x31", bus.read_data2, 32'h0);

    // Immediate generator table.
    foreach (imm_vecs[i]) begin
      bus.instruction = imm_vecs[i].inst;
      #1;
      check(imm_vecs[i].name, bus.imm_extended, imm_vecs[i].imm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
